// File: rtl/fetch_stage_bpred.sv
// Fetch stage: holds the fetch PC, drives the instruction-memory read port and
// predicts the next PC through a direct-mapped BTB with 2-bit counters.
module fetch_stage_bpred #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_rd_en,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            ex_update_en,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_mispredict,
    input  logic [XLEN-1:0] ex_redirect_pc,
    output logic            flush_fd,
    output logic            flush_de
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0] pc_q, pc_d;

    logic            valid_q  [BTB_ENTRIES];
    logic            valid_d  [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [TAGW-1:0] tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];
    logic [XLEN-1:0] target_d [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic [1:0]      ctr_d    [BTB_ENTRIES];

    logic [IDX-1:0]  lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag;
    logic            lk_hit, up_hit;
    logic [XLEN-1:0] pc_plus4;

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    always_comb begin
        lk_idx        = pc_q[IDX+1:2];
        lk_tag        = pc_q[XLEN-1:IDX+2];
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pc_plus4      = pc_q + XLEN'(4);
        pred_taken_f  = lk_hit && ctr_q[lk_idx][1];
        pred_target_f = pred_taken_f ? target_q[lk_idx] : pc_plus4;

        up_idx = ex_pc[IDX+1:2];
        up_tag = ex_pc[XLEN-1:IDX+2];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    always_comb begin
        pc_d = pc_q;
        if (rst)
            pc_d = RESET_PC;
        else if (ex_mispredict)
            pc_d = ex_redirect_pc;
        else if (!stall_f)
            pc_d = pred_target_f;
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    generate
        for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
            always_comb begin
                valid_d[gi]  = valid_q[gi];
                tag_d[gi]    = tag_q[gi];
                target_d[gi] = target_q[gi];
                ctr_d[gi]    = ctr_q[gi];
                if (ex_update_en && (up_idx == IDX'(gi))) begin
                    if (up_hit) begin
                        if (ex_taken) begin
                            ctr_d[gi]    = (ctr_q[gi] == 2'b11) ? 2'b11 : ctr_q[gi] + 2'b01;
                            target_d[gi] = ex_target;
                        end else begin
                            ctr_d[gi] = (ctr_q[gi] == 2'b00) ? 2'b00 : ctr_q[gi] - 2'b01;
                        end
                    end else if (ex_taken) begin
                        // Miss on a taken branch overwrites whatever lived in this slot.
                        valid_d[gi]  = 1'b1;
                        tag_d[gi]    = up_tag;
                        target_d[gi] = ex_target;
                        ctr_d[gi]    = 2'b10;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= 2'b01;
                end else begin
                    valid_q[gi]  <= valid_d[gi];
                    tag_q[gi]    <= tag_d[gi];
                    target_q[gi] <= target_d[gi];
                    ctr_q[gi]    <= ctr_d[gi];
                end
            end
        end
    endgenerate

    assign pc_f       = pc_q;
    assign imem_addr  = pc_q;
    assign instr_f    = imem_rdata;
    assign imem_rd_en = ~rst & ~stall_f;
    assign flush_fd   = ex_mispredict & ~rst;
    assign flush_de   = ex_mispredict & ~rst;

endmodule

// File: tb/tb_fetch_stage_bpred.sv
// Directed bench for fetch_stage_bpred: sequential fetch, BTB allocate/predict,
// counter hysteresis, redirect with stall, aliasing, mid-run reset and PC wrap.
module tb_fetch_stage_bpred;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        ex_update_en;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic        flush_fd;
    logic        flush_de;

    int vectors = 0;
    int errors  = 0;

    fetch_stage_bpred #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
        .pc_f(pc_f), .instr_f(instr_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .ex_update_en(ex_update_en), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_mispredict(ex_mispredict),
        .ex_redirect_pc(ex_redirect_pc),
        .flush_fd(flush_fd), .flush_de(flush_de)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr ^ KEY;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed %h expected %h", vectors, tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_f       = 1'b0;
        ex_update_en  = 1'b0;
        ex_taken      = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        ex_update_en = 1'b1;
        ex_pc        = pc;
        ex_taken     = tk;
        ex_target    = tgt;
    endtask

    task automatic redir(input logic [31:0] pc);
        ex_mispredict  = 1'b1;
        ex_redirect_pc = pc;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        ex_pc = '0;
        ex_target = '0;
        redir(32'h80);
        cyc(); cyc(); #1;
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_rd_en", {31'b0, imem_rd_en}, 32'd0);
        chk("rst_flush_fd", {31'b0, flush_fd}, 32'd0);
        chk("rst_flush_de", {31'b0, flush_de}, 32'd0);
        chk("rst_pred", {31'b0, pred_taken_f}, 32'd0);

        // Sequential fetch from RESET_PC
        rst = 1'b0;
        idle();
        #1;
        chk("seq_pc0", pc_f, 32'h0);
        chk("seq_rd_en", {31'b0, imem_rd_en}, 32'd1);
        chk("seq_addr", imem_addr, 32'h0);
        chk("seq_instr", instr_f, KEY);
        chk("seq_tgt0", pred_target_f, 32'h4);
        cyc(); chk("seq_pc4", pc_f, 32'h4);
        cyc(); chk("seq_pc8", pc_f, 32'h8);
        cyc(); chk("seq_pcC", pc_f, 32'hC);

        // Allocate 0x10 -> 0x40 and predict it the next cycle
        upd(32'h10, 1'b1, 32'h40);
        #1;
        chk("seq_tgtC", pred_target_f, 32'h10);
        chk("seq_predC", {31'b0, pred_taken_f}, 32'd0);
        cyc(); idle(); #1;
        chk("alloc_pc", pc_f, 32'h10);
        chk("alloc_pred", {31'b0, pred_taken_f}, 32'd1);
        chk("alloc_tgt", pred_target_f, 32'h40);
        cyc();
        chk("alloc_next", pc_f, 32'h40);

        // Counter 2 -> 3 -> 3 -> 3 -> 2
        for (int i = 0; i < 3; i++) begin
            upd(32'h10, 1'b1, 32'h40);
            cyc();
        end
        upd(32'h10, 1'b0, 32'h0);
        cyc(); idle(); #1;
        chk("hyst_pc50", pc_f, 32'h50);
        chk("alias_pred50", {31'b0, pred_taken_f}, 32'd0);
        redir(32'h10);
        #1;
        chk("redir_flush_fd", {31'b0, flush_fd}, 32'd1);
        cyc(); idle(); #1;
        chk("hyst_pc10", pc_f, 32'h10);
        chk("hyst_pred_ctr2", {31'b0, pred_taken_f}, 32'd1);

        // Same-index update and lookup: lookup sees the old counter
        upd(32'h10, 1'b0, 32'h0);
        #1;
        chk("bypass_pred", {31'b0, pred_taken_f}, 32'd1);
        chk("bypass_tgt", pred_target_f, 32'h40);
        cyc(); idle(); #1;
        chk("bypass_next", pc_f, 32'h40);
        redir(32'h10);
        cyc(); idle(); #1;
        chk("hyst_pred_ctr1", {31'b0, pred_taken_f}, 32'd0);
        chk("hyst_tgt_ctr1", pred_target_f, 32'h14);
        cyc();
        chk("hyst_next", pc_f, 32'h14);

        // Mispredict overrides stall
        stall_f = 1'b1;
        redir(32'h80);
        #1;
        chk("stall_flush_fd", {31'b0, flush_fd}, 32'd1);
        chk("stall_flush_de", {31'b0, flush_de}, 32'd1);
        chk("stall_rd_en", {31'b0, imem_rd_en}, 32'd0);
        cyc();
        ex_mispredict = 1'b0;
        #1;
        chk("stall_redir_pc", pc_f, 32'h80);
        chk("stall_noflush", {31'b0, flush_fd}, 32'd0);
        cyc();
        chk("stall_hold", pc_f, 32'h80);
        idle();

        // Aliasing: 0x10 and 0x50 share index 4
        upd(32'h10, 1'b1, 32'h40);
        cyc(); idle();
        redir(32'h50);
        cyc(); idle(); #1;
        chk("alias_pc", pc_f, 32'h50);
        chk("alias_pred", {31'b0, pred_taken_f}, 32'd0);
        chk("alias_tgt", pred_target_f, 32'h54);
        cyc();
        chk("alias_next", pc_f, 32'h54);
        redir(32'h10);
        cyc(); idle(); #1;
        chk("alias_own_pred", {31'b0, pred_taken_f}, 32'd1);
        upd(32'h50, 1'b1, 32'h90);
        redir(32'h50);
        cyc(); idle(); #1;
        chk("evict_pred50", {31'b0, pred_taken_f}, 32'd1);
        chk("evict_tgt50", pred_target_f, 32'h90);
        cyc();
        chk("evict_next", pc_f, 32'h90);
        redir(32'h10);
        cyc(); idle(); #1;
        chk("evict_pred10", {31'b0, pred_taken_f}, 32'd0);
        chk("evict_tgt10", pred_target_f, 32'h14);

        // Retrain 0x10, then reset with redirect and update pending
        upd(32'h10, 1'b1, 32'h40);
        redir(32'h10);
        cyc(); idle(); #1;
        chk("pre_rst_pred", {31'b0, pred_taken_f}, 32'd1);
        rst = 1'b1;
        redir(32'h80);
        upd(32'h10, 1'b1, 32'h40);
        #1;
        chk("midrst_flush_fd", {31'b0, flush_fd}, 32'd0);
        chk("midrst_flush_de", {31'b0, flush_de}, 32'd0);
        cyc();
        rst = 1'b0;
        idle();
        #1;
        chk("midrst_pc", pc_f, 32'h0);
        chk("midrst_pred", {31'b0, pred_taken_f}, 32'd0);
        redir(32'h10);
        cyc(); idle(); #1;
        chk("midrst_cleared_pc", pc_f, 32'h10);
        chk("midrst_cleared_pred", {31'b0, pred_taken_f}, 32'd0);
        chk("midrst_cleared_tgt", pred_target_f, 32'h14);

        // PC wraps modulo 2^32
        redir(32'hFFFF_FFFC);
        cyc(); idle(); #1;
        chk("wrap_pc", pc_f, 32'hFFFF_FFFC);
        chk("wrap_tgt", pred_target_f, 32'h0);
        cyc();
        chk("wrap_next", pc_f, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
